// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/half/word accesses onto a word-wide data bus,
// splitting misaligned accesses into two word transfers and serving one hardware-counter address.
`ifndef HARDWARE_COUNTER_ADDR
`define HARDWARE_COUNTER_ADDR 32'hFFFF_FFF0
`endif

module load_store_unit #(
    parameter int          ADDR_W  = 14,
    parameter logic [31:0] HC_ADDR = `HARDWARE_COUNTER_ADDR
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        mem_load,
    input  logic [1:0]        mem_store,
    input  logic [31:0]       addr,
    input  logic [31:0]       write_data,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    input  logic [31:0]       hc_data
);

    // state | meaning
    // IDLE  | ready to accept an operation
    // ACC0  | first word request on the bus, waiting for grant
    // WAIT0 | first word read outstanding
    // ACC1  | second word request (misaligned access spilling into next word)
    // WAIT1 | second word read outstanding
    // RESP  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;

    state_t              state;
    logic                is_store;
    logic [2:0]          load_op;
    logic [1:0]          offset;
    logic [2:0]          size;
    logic                split;
    logic [ADDR_W-1:0]   word_addr;
    logic [31:0]         wdata_q;
    logic [31:0]         word0;
    logic [31:0]         resp_data_q;

    logic [2:0]          acc_size;
    logic                acc_is_load;
    logic [7:0]          lane_mask;
    logic                in_acc;

    function automatic logic [31:0] extract(input logic [31:0] w1, input logic [31:0] w0,
                                            input logic [1:0] off, input logic [2:0] op);
        logic [63:0] sh;
        logic [31:0] r;
        sh = {w1, w0} >> {off, 3'b000};
        case (op)
            3'b001:  r = {{24{sh[7]}}, sh[7:0]};
            3'b010:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h0, sh[7:0]};
            3'b101:  r = {16'h0, sh[15:0]};
            default: r = sh[31:0];
        endcase
        return r;
    endfunction

    // Access size of the operation being presented; unknown load codes act as no-ops.
    always_comb begin
        acc_size    = 3'd0;
        acc_is_load = 1'b0;
        if (mem_store != 2'b00) begin
            acc_size = (mem_store == 2'b11) ? 3'd4 : {1'b0, mem_store};
        end else begin
            case (mem_load)
                3'b001, 3'b100: begin acc_size = 3'd1; acc_is_load = 1'b1; end
                3'b010, 3'b101: begin acc_size = 3'd2; acc_is_load = 1'b1; end
                3'b011:         begin acc_size = 3'd4; acc_is_load = 1'b1; end
                default:        begin acc_size = 3'd0; acc_is_load = 1'b0; end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state       <= IDLE;
            is_store    <= 1'b0;
            load_op     <= 3'b000;
            offset      <= 2'b00;
            size        <= 3'd0;
            split       <= 1'b0;
            word_addr   <= '0;
            wdata_q     <= 32'h0;
            word0       <= 32'h0;
            resp_data_q <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    is_store  <= (mem_store != 2'b00);
                    load_op   <= mem_load;
                    offset    <= addr[1:0];
                    size      <= acc_size;
                    split     <= ({2'b00, addr[1:0]} + {1'b0, acc_size}) > 4'd4;
                    word_addr <= addr[ADDR_W+1:2];
                    wdata_q   <= write_data;
                    if (mem_store != 2'b00) begin
                        state <= ACC0;
                    end else if (!acc_is_load) begin
                        resp_data_q <= 32'h0;
                        state       <= RESP;
                    end else if (mem_load == 3'b011 && addr == HC_ADDR) begin
                        resp_data_q <= hc_data;
                        state       <= RESP;
                    end else begin
                        state <= ACC0;
                    end
                end
                ACC0: if (bus_gnt) begin
                    if (!is_store) begin
                        state <= WAIT0;
                    end else if (split) begin
                        state <= ACC1;
                    end else begin
                        resp_data_q <= 32'h0;
                        state       <= RESP;
                    end
                end
                ACC1: if (bus_gnt) begin
                    if (is_store) begin
                        resp_data_q <= 32'h0;
                        state       <= RESP;
                    end else begin
                        state <= WAIT1;
                    end
                end
                WAIT0: if (bus_rvalid) begin
                    word0 <= bus_rdata;
                    if (split) begin
                        state <= ACC1;
                    end else begin
                        resp_data_q <= extract(32'h0, bus_rdata, offset, load_op);
                        state       <= RESP;
                    end
                end
                WAIT1: if (bus_rvalid) begin
                    resp_data_q <= extract(bus_rdata, word0, offset, load_op);
                    state       <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bytes touched across the two words: low nibble for ACC0, high nibble for ACC1.
    assign lane_mask = ((8'd1 << size) - 8'd1) << offset;
    assign in_acc    = (state == ACC0) || (state == ACC1);

    always_comb begin
        bus_req   = in_acc;
        bus_we    = in_acc && is_store;
        bus_addr  = (state == ACC1) ? word_addr + 1'b1 : word_addr;
        bus_wdata = 32'h0;
        bus_wstrb = 4'b0000;
        if (in_acc && is_store) begin
            if (state == ACC1) begin
                bus_wdata = wdata_q >> {(3'd4 - {1'b0, offset}), 3'b000};
                bus_wstrb = lane_mask[7:4];
            end else begin
                bus_wdata = wdata_q << {offset, 3'b000};
                bus_wstrb = lane_mask[3:0];
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-wide memory responder on the bus,
// hand-computed results, latencies, bus write patterns and reset abort behaviour.
module tb_load_store_unit;

    localparam int          ADDR_W = 14;
    localparam logic [31:0] HC     = 32'h0000_3000;

    logic              CLK = 1'b0;
    logic              NRST;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        mem_load;
    logic [1:0]        mem_store;
    logic [31:0]       addr;
    logic [31:0]       write_data;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              busy;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;
    logic [31:0]       hc_data;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .HC_ADDR(HC)) dut (
        .CLK(CLK), .NRST(NRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_load(mem_load), .mem_store(mem_store),
        .addr(addr), .write_data(write_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .hc_data(hc_data)
    );

    always #5 CLK = ~CLK;

    // Memory responder: writes apply strobes; reads return data one cycle after grant.
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              auto_en;
    logic              rv_auto = 1'b0;
    logic [31:0]       rd_auto = 32'h0;
    logic              rv_man;
    logic [31:0]       rd_man;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [3:0]        wr_strb_q[$];
    logic [31:0]       wr_data_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    int                req_cycles = 0;

    always @(posedge CLK) begin
        rv_auto <= 1'b0;
        if (bus_req) req_cycles <= req_cycles + 1;
        if (bus_req && bus_gnt) begin
            if (bus_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus_wstrb[b]) mem[bus_addr][8*b +: 8] <= bus_wdata[8*b +: 8];
                wr_addr_q.push_back(bus_addr);
                wr_strb_q.push_back(bus_wstrb);
                wr_data_q.push_back(bus_wdata);
            end else begin
                rv_auto <= auto_en;
                rd_auto <= mem[bus_addr];
                rd_addr_q.push_back(bus_addr);
            end
        end
    end

    assign bus_rvalid = auto_en ? rv_auto : rv_man;
    assign bus_rdata  = auto_en ? rd_auto : rd_man;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd);
        @(negedge CLK);
        req_valid  = 1'b1;
        mem_load   = ld;
        mem_store  = st;
        addr       = a;
        write_data = wd;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        mem_load  = 3'b000;
        mem_store = 2'b00;
        lat = 1;
        @(negedge CLK);
        while (!resp_valid && lat < 30) begin
            @(negedge CLK);
            lat++;
        end
        rd = resp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        int          w0;
        int          r0;
        int          q0;

        NRST = 1'b0; req_valid = 1'b0; mem_load = 3'b000; mem_store = 2'b00;
        addr = 32'h0; write_data = 32'h0; bus_gnt = 1'b1; hc_data = 32'h0;
        auto_en = 1'b1; rv_man = 1'b0; rd_man = 32'h0;

        #12;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_data", resp_data, 32'h0);
        @(negedge CLK);
        NRST = 1'b1;

        // Aligned SW: one write, word 0x040, all strobes, latency 2.
        w0 = wr_addr_q.size();
        run_op(3'b000, 2'b11, 32'h100, 32'hDEADBEEF, lat, rd);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_resp", rd, 32'h0);
        chk("sw_nwr", 32'(wr_addr_q.size() - w0), 32'd1);
        chk("sw_addr", 32'(wr_addr_q[w0]), 32'h040);
        chk("sw_strb", 32'(wr_strb_q[w0]), 32'hF);
        chk("sw_data", wr_data_q[w0], 32'hDEADBEEF);

        // Store wins over a simultaneous load request.
        w0 = wr_addr_q.size();
        r0 = rd_addr_q.size();
        run_op(3'b001, 2'b11, 32'h100, 32'h80112233, lat, rd);
        chk("prio_nwr", 32'(wr_addr_q.size() - w0), 32'd1);
        chk("prio_nrd", 32'(rd_addr_q.size() - r0), 32'd0);
        chk("prio_lat", 32'(lat), 32'd2);

        r0 = rd_addr_q.size();
        run_op(3'b001, 2'b00, 32'h103, 32'h0, lat, rd);
        chk("lb_data", rd, 32'hFFFFFF80);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_raddr", 32'(rd_addr_q[r0]), 32'h040);
        run_op(3'b100, 2'b00, 32'h103, 32'h0, lat, rd);
        chk("lbu_data", rd, 32'h00000080);

        // Misaligned LW crossing words 0x040/0x041.
        run_op(3'b000, 2'b11, 32'h104, 32'h11223344, lat, rd);
        run_op(3'b000, 2'b11, 32'h100, 32'hAABBCCDD, lat, rd);
        r0 = rd_addr_q.size();
        run_op(3'b011, 2'b00, 32'h102, 32'h0, lat, rd);
        chk("lw_split_data", rd, 32'h3344AABB);
        chk("lw_split_lat", 32'(lat), 32'd5);
        chk("lw_split_nrd", 32'(rd_addr_q.size() - r0), 32'd2);
        chk("lw_split_a0", 32'(rd_addr_q[r0]), 32'h040);
        chk("lw_split_a1", 32'(rd_addr_q[r0+1]), 32'h041);

        // SH at the top of memory wraps to word 0.
        w0 = wr_addr_q.size();
        run_op(3'b000, 2'b10, 32'h0000FFFF, 32'h00001234, lat, rd);
        chk("sh_wrap_lat", 32'(lat), 32'd3);
        chk("sh_wrap_nwr", 32'(wr_addr_q.size() - w0), 32'd2);
        chk("sh_wrap_a0", 32'(wr_addr_q[w0]), 32'h3FFF);
        chk("sh_wrap_s0", 32'(wr_strb_q[w0]), 32'h8);
        chk("sh_wrap_d0", wr_data_q[w0], 32'h34000000);
        chk("sh_wrap_a1", 32'(wr_addr_q[w0+1]), 32'h0000);
        chk("sh_wrap_s1", 32'(wr_strb_q[w0+1]), 32'h1);
        chk("sh_wrap_d1", wr_data_q[w0+1], 32'h00000012);
        run_op(3'b101, 2'b00, 32'h0000FFFF, 32'h0, lat, rd);
        chk("lhu_wrap_data", rd, 32'h00001234);
        chk("lhu_wrap_lat", 32'(lat), 32'd5);

        // Halfword at offset 2, sign and zero extension.
        w0 = wr_addr_q.size();
        run_op(3'b000, 2'b10, 32'h202, 32'h00008001, lat, rd);
        chk("sh_strb", 32'(wr_strb_q[w0]), 32'hC);
        chk("sh_data", wr_data_q[w0], 32'h80010000);
        chk("sh_addr", 32'(wr_addr_q[w0]), 32'h080);
        run_op(3'b010, 2'b00, 32'h202, 32'h0, lat, rd);
        chk("lh_data", rd, 32'hFFFF8001);
        chk("lh_lat", 32'(lat), 32'd3);
        run_op(3'b101, 2'b00, 32'h202, 32'h0, lat, rd);
        chk("lhu_data", rd, 32'h00008001);

        // SB at offset 1.
        w0 = wr_addr_q.size();
        run_op(3'b000, 2'b01, 32'h201, 32'h000000A5, lat, rd);
        chk("sb_strb", 32'(wr_strb_q[w0]), 32'h2);
        chk("sb_data", wr_data_q[w0], 32'h0000A500);

        // No-op and hardware counter: one cycle, no bus traffic.
        q0 = req_cycles;
        run_op(3'b000, 2'b00, 32'h100, 32'h0, lat, rd);
        chk("noop_lat", 32'(lat), 32'd1);
        chk("noop_resp", rd, 32'h0);
        hc_data = 32'h00001234;
        run_op(3'b011, 2'b00, HC, 32'h0, lat, rd);
        chk("hc_lat", 32'(lat), 32'd1);
        chk("hc_resp", rd, 32'h00001234);
        chk("hc_noop_busreq", 32'(req_cycles - q0), 32'd0);

        // Grant held low: request stays on the bus; then reset aborts the read.
        bus_gnt = 1'b0;
        auto_en = 1'b0;
        @(negedge CLK);
        req_valid = 1'b1; mem_load = 3'b011; addr = 32'h200;
        @(posedge CLK);
        #1;
        req_valid = 1'b0; mem_load = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_req", {31'h0, bus_req}, 32'h1);
            chk("stall_addr", 32'(bus_addr), 32'h080);
        end
        @(negedge CLK);
        chk("stall_busy", {31'h0, busy}, 32'h1);
        bus_gnt = 1'b1;
        @(negedge CLK);
        chk("wait0_req", {31'h0, bus_req}, 32'h0);
        chk("wait0_busy", {31'h0, busy}, 32'h1);
        NRST = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("abort_resp_data", resp_data, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        @(negedge CLK);
        NRST = 1'b1;
        rv_man = 1'b1;
        rd_man = 32'hCAFEF00D;
        @(negedge CLK);
        rv_man = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("late_rvalid_resp", {31'h0, resp_valid}, 32'h0);
            chk("late_rvalid_busy", {31'h0, busy}, 32'h0);
        end
        chk("late_rvalid_data", resp_data, 32'h0);

        // Normal operation resumes after the abort.
        auto_en = 1'b1;
        run_op(3'b011, 2'b00, 32'h100, 32'h0, lat, rd);
        chk("recover_data", rd, 32'hAABBCCDD);
        chk("recover_lat", 32'(lat), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the data memory bus.
REQ-002 SHALL have parameter HC_ADDR, default `HARDWARE_COUNTER_ADDR, byte address served by the hardware counter instead of memory.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port NRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  pipeline presents a memory operation.
REQ-006 SHALL have port req_ready  output  1  unit accepts an operation this cycle.
REQ-007 SHALL have port mem_load  input  3  001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 000 none.
REQ-008 SHALL have port mem_store  input  2  01 SB, 10 SH, 11 SW, 00 none.
REQ-009 SHALL have ports addr  input  32  byte address; write_data  input  32  store data (LSB-aligned).
REQ-010 SHALL have ports resp_valid  output  1  one-cycle completion pulse; resp_data  output  32  load result.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have ports bus_req  output  1; bus_we  output  1; bus_addr  output  ADDR_W  word address; bus_wdata  output  32; bus_wstrb  output  4.
REQ-013 SHALL have ports bus_gnt  input  1; bus_rvalid  input  1; bus_rdata  input  32; hc_data  input  32.

Function
REQ-014 SHALL implement FSM states IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP; req_ready = (state==IDLE).
REQ-015 SHALL accept on rising edge with req_valid&req_ready, latching op, addr, write_data; mem_store!=00 takes priority over mem_load (load ignored).
REQ-016 SHALL treat mem_load==000 and mem_store==00 as no-op: IDLE->RESP, resp_data=0, no bus activity.
REQ-017 SHALL serve LW with addr==HC_ADDR as IDLE->RESP with resp_data=hc_data sampled at acceptance, no bus activity.
REQ-018 SHALL otherwise go IDLE->ACC0; access size 1/2/4 bytes; offset=addr[1:0]; split=(offset+size>4).
REQ-019 SHALL in ACC0/ACC1 hold bus_req=1 with stable bus_addr/bus_we/bus_wdata/bus_wstrb until an edge with bus_gnt=1.
REQ-020 SHALL use word address addr[ADDR_W+1:2] in ACC0 and that value +1 modulo 2^ADDR_W in ACC1 (wrap at top of memory).
REQ-021 SHALL for stores drive bus_wstrb = bytes offset..min(3,offset+size-1) and bus_wdata = write_data<<(8*offset) in ACC0; in ACC1 strobe low (offset+size-4) bytes, bus_wdata = write_data>>(8*(4-offset)).
REQ-022 SHALL drive bus_we=0, bus_wstrb=0000 for loads; bus_req, bus_we, bus_wstrb = 0 outside ACC0/ACC1.
REQ-023 SHALL transition on grant: store ACC0->ACC1 if split else RESP; store ACC1->RESP; load ACC0->WAIT0, ACC1->WAIT1.
REQ-024 SHALL in WAIT0/WAIT1 capture bus_rdata on edge with bus_rvalid=1; WAIT0->ACC1 if split else RESP; WAIT1->RESP; bus_rvalid ignored in all other states.
REQ-025 SHALL form load result from {word1,word0}>>(8*offset), take size bytes, sign-extend for LB/LH, zero-extend for LBU/LHU.
REQ-026 SHALL in RESP assert resp_valid=1 for exactly one cycle with resp_data valid (0 for stores), then return to IDLE; resp_data holds value until next RESP.
REQ-027 SHALL with bus_gnt tied 1 and rvalid one cycle after grant give aligned load acceptance-to-resp_valid latency 3 cycles, aligned store 2, split load 5, split store 3, no-op/HC 1.

Reset
REQ-028 SHALL on NRST low immediately force IDLE, resp_valid=0, resp_data=0, bus_req=0, busy=0, discarding any in-flight access.
REQ-029 SHALL ignore bus_rvalid arriving after reset release for an aborted access; first acceptance possible on first rising edge with NRST high.

Verification
REQ-030 SW addr 0x100 data 0xDEADBEEF, gnt=1 -> one bus write, bus_addr 0x040, wstrb 1111, resp_valid 2 cycles after accept.
REQ-031 LB addr 0x103, memory word 0x80112233 -> resp_data 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-032 LW addr 0x102, words 0x40=0xAABBCCDD, 0x41=0x11223344 -> reads 0x040 then 0x041, resp_data 0x3344AABB, latency 5.
REQ-033 SH addr 0xFFFF (ADDR_W 14) data 0x1234 -> writes word 0x3FFF wstrb 1000 wdata 0x34000000, then word 0x0000 wstrb 0001 wdata 0x00000012.
REQ-034 Load with bus_gnt low 3 cycles -> bus_req and bus_addr stable 3 cycles, no state advance; NRST pulsed low in WAIT0 -> IDLE, no resp_valid, late rvalid ignored.
REQ-035 LW addr HC_ADDR, hc_data 0x00001234 -> resp_data 0x00001234 next cycle, bus_req never asserted.
